// File: rtl/j6502_clock_gen_pkg.sv
// Shared definitions for the J6502 clock/reset generator: controller states,
// default timing constants and a small window-decode helper.
package j6502_clock_gen_pkg;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HALT       = 2'd2,
    S_STEP       = 2'd3
  } state_t;

  localparam int DEF_DIV        = 8;
  localparam int DEF_DEAD       = 1;
  localparam int DEF_RES_CYCLES = 2;
  localparam int DEF_CNT_W      = 16;

  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/j6502_clock_gen_phase_gen.sv
// Phase counter plus registered phi1/phi2 and phi2 edge-strobe decode.
// The counter only moves while adv is high; wrap flags the last cycle of a period.
module j6502_phase_gen
  import j6502_clock_gen_pkg::*;
#(
  parameter int DIV  = DEF_DIV,
  parameter int DEAD = DEF_DEAD
) (
  input  logic clk,
  input  logic srst,
  input  logic adv,
  output logic phi1,
  output logic phi2,
  output logic phi2_rise,
  output logic phi2_fall,
  output logic wrap
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_phi1;
  logic          r_phi2;
  logic          r_phi2_rise;
  logic          r_phi2_fall;

  assign wrap = (r_cnt == CW'(DIV - 1));

  always_comb begin
    w_cnt_next = r_cnt;
    if (adv) begin
      w_cnt_next = wrap ? '0 : r_cnt + CW'(1);
    end
  end

  // Outputs decode the upcoming count so they line up with r_cnt after the edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt       <= '0;
      r_phi1      <= 1'b0;
      r_phi2      <= 1'b0;
      r_phi2_rise <= 1'b0;
      r_phi2_fall <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_phi1      <= in_window(int'(w_cnt_next), DEAD, DIV / 2 - 1);
      r_phi2      <= in_window(int'(w_cnt_next), DIV / 2 + DEAD, DIV - 1);
      r_phi2_rise <= (int'(w_cnt_next) == DIV / 2 + DEAD);
      r_phi2_fall <= adv & wrap;
    end
  end

  assign phi1      = r_phi1;
  assign phi2      = r_phi2;
  assign phi2_rise = r_phi2_rise;
  assign phi2_fall = r_phi2_fall;

endmodule

// File: rtl/j6502_clock_gen.sv
// J6502 two-phase clock generator: CPU reset sequencing, run/halt/single-step
// control on phi-period boundaries, and a completed-period counter.
module j6502_clock_gen
  import j6502_clock_gen_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int DEAD       = DEF_DEAD,
  parameter int RES_CYCLES = DEF_RES_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             fst_clk,
  input  logic             res,
  input  logic             run,
  input  logic             step,
  output logic             phi1,
  output logic             phi2,
  output logic             phi2_rise,
  output logic             phi2_fall,
  output logic             res_n,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int RCW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [RCW-1:0]   r_rcnt;
  logic [RCW-1:0]   w_rcnt_next;
  logic             r_res_n;
  logic             w_res_n_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] w_cyc_cnt_next;
  logic             w_adv;
  logic             w_wrap;

  assign w_adv = (r_state != S_HALT);

  j6502_phase_gen #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) u_phase (
    .clk       (fst_clk),
    .srst      (res),
    .adv       (w_adv),
    .phi1      (phi1),
    .phi2      (phi2),
    .phi2_rise (phi2_rise),
    .phi2_fall (phi2_fall),
    .wrap      (w_wrap)
  );

  always_comb begin
    w_state_next   = r_state;
    w_rcnt_next    = r_rcnt;
    w_res_n_next   = r_res_n;
    w_cyc_cnt_next = r_cyc_cnt;
    // The period that releases res_n is not counted: r_res_n is still 0 then.
    if (w_adv && w_wrap && r_res_n) begin
      w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
    end
    case (r_state)
      S_RESET_HOLD: begin
        if (w_wrap) begin
          if (r_rcnt == RCW'(RES_CYCLES - 1)) begin
            w_res_n_next = 1'b1;
            w_state_next = run ? S_RUN : S_HALT;
          end else begin
            w_rcnt_next = r_rcnt + RCW'(1);
          end
        end
      end
      S_RUN: begin
        if (w_wrap && !run) w_state_next = S_HALT;
      end
      S_HALT: begin
        if (run)       w_state_next = S_RUN;
        else if (step) w_state_next = S_STEP;
      end
      S_STEP: begin
        if (w_wrap) w_state_next = run ? S_RUN : S_HALT;
      end
      default: w_state_next = S_RESET_HOLD;
    endcase
  end

  always_ff @(posedge fst_clk) begin
    if (res) begin
      r_state   <= S_RESET_HOLD;
      r_rcnt    <= '0;
      r_res_n   <= 1'b0;
      r_halted  <= 1'b0;
      r_cyc_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rcnt    <= w_rcnt_next;
      r_res_n   <= w_res_n_next;
      r_halted  <= (w_state_next == S_HALT);
      r_cyc_cnt <= w_cyc_cnt_next;
    end
  end

  assign res_n   = r_res_n;
  assign halted  = r_halted;
  assign cyc_cnt = r_cyc_cnt;

endmodule
